// File: rtl/us_timer_sched.sv
// us_timer_sched
// Four-channel microsecond timer scheduler. A prescaler derives a one-cycle
// tick every DIV system clocks. A round-robin arbiter grants at most one
// delay load per cycle. Each granted channel counts its delay down in ticks
// and pulses expire when the delay has elapsed.
//
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   tick    one-cycle pulse every DIV cycles
//   req     per-channel load request, held until ack
//   delay   channel k delay in bits [k*CW +: CW], stable while req[k] is high
//   cancel  per-channel one-cycle stop request
//   ack     registered one-cycle grant pulse
//   busy    channel is counting
//   expire  registered one-cycle expiry pulse

module us_timer_sched #(
    parameter int DIV = 48,
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              tick,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*CW-1:0] delay,
    input  logic [NCH-1:0]    cancel,
    output logic [NCH-1:0]    ack,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    expire
);

    localparam int              PW        = $clog2(DIV);
    localparam int              QW        = $clog2(NCH);
    localparam logic [PW-1:0]   PCNT_LAST = PW'(DIV - 1);
    localparam logic [QW-1:0]   PTR_LAST  = QW'(NCH - 1);
    localparam logic [QW:0]     NCH_W     = (QW + 1)'(NCH);

    logic [PW-1:0]  pcnt;
    logic [QW-1:0]  ptr;
    logic [CW-1:0]  cnt [NCH];
    logic [NCH-1:0] eligible;
    logic [NCH-1:0] grant;
    logic [QW-1:0]  grant_idx;
    logic           grant_found;
    logic [QW:0]    search_pos;

    // Tick is decoded from the prescaler register so it is glitch-free and
    // lands exactly on the last count of each period.
    assign tick = (pcnt == PCNT_LAST);

    // Prescaler: free-running 0..DIV-1 counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (pcnt == PCNT_LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Round-robin search starting at ptr. A channel whose ack is currently
    // high is skipped so a requester that is still dropping req is not
    // granted twice; a cancelled channel is skipped and stays pending.
    always_comb begin
        eligible    = req & ~cancel & ~ack;
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        search_pos  = '0;
        for (int i = 0; i < NCH; i++) begin
            search_pos = {1'b0, ptr} + (QW + 1)'(i);
            if (search_pos >= NCH_W) begin
                search_pos = search_pos - NCH_W;
            end
            if (!grant_found && eligible[search_pos[QW-1:0]]) begin
                grant_found                 = 1'b1;
                grant[search_pos[QW-1:0]]   = 1'b1;
                grant_idx                   = search_pos[QW-1:0];
            end
        end
    end

    // Pointer moves to the channel after the winner; holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_found) begin
            ptr <= (grant_idx == PTR_LAST) ? '0 : grant_idx + QW'(1);
        end
    end

    // Per-channel counters. Priority is cancel, then load, then tick
    // decrement; a load in the expiry cycle therefore suppresses that expire.
    // A zero-delay load expires immediately without ever going busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack    <= '0;
            busy   <= '0;
            expire <= '0;
            for (int k = 0; k < NCH; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            ack    <= grant;
            expire <= '0;
            for (int k = 0; k < NCH; k++) begin
                if (cancel[k]) begin
                    cnt[k]  <= '0;
                    busy[k] <= 1'b0;
                end else if (grant[k]) begin
                    if (delay[k*CW +: CW] != '0) begin
                        cnt[k]  <= delay[k*CW +: CW];
                        busy[k] <= 1'b1;
                    end else begin
                        cnt[k]    <= '0;
                        busy[k]   <= 1'b0;
                        expire[k] <= 1'b1;
                    end
                end else if (tick && busy[k]) begin
                    if (cnt[k] == CW'(1)) begin
                        cnt[k]    <= '0;
                        busy[k]   <= 1'b0;
                        expire[k] <= 1'b1;
                    end else begin
                        cnt[k] <= cnt[k] - CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_us_timer_sched.sv
// tb_us_timer_sched
// Self-checking bench for us_timer_sched. A behavioural model predicts every
// output on every cycle: ticks come from the cycle number modulo DIV, and a
// loaded channel is given an absolute expiry cycle computed from the tick
// schedule. Directed sequences and a vector table add fixed expectations for
// the documented corner cases; a random phase exercises overlaps.

module tb_us_timer_sched;

    localparam int DIV = 48;
    localparam int NCH = 4;
    localparam int CW  = 16;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic [3:0]  req;
    logic [3:0]  cancel;
    logic [3:0]  ack;
    logic [3:0]  busy;
    logic [3:0]  expire;
    logic [63:0] delay;

    us_timer_sched #(.DIV(DIV), .NCH(NCH), .CW(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .req    (req),
        .delay  (delay),
        .cancel (cancel),
        .ack    (ack),
        .busy   (busy),
        .expire (expire)
    );

    // Free-running 100 MHz-style clock for simulation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;
    int cyc        = 0;

    // Model state describing the outputs of the current cycle.
    logic [3:0] busyM;
    logic [3:0] ackM;
    logic [3:0] expM;
    int         expAt [4];
    int         ptrM;

    // Requester behaviour.
    logic [3:0]  want;
    logic [3:0]  autoRe;
    logic [3:0]  cancelNext;
    int          reraiseAt [4];
    logic [15:0] delayReg [4];

    typedef struct {
        int         cyc;
        logic [3:0] raise;
        logic [3:0] ackE;
        logic [3:0] busyE;
        logic [3:0] expE;
    } vec_t;

    vec_t tbl [9];

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic tickE;
        tickE = ((cyc % DIV) == DIV - 1);
        checkVal("tick",   32'(tick),   32'(tickE));
        checkVal("ack",    32'(ack),    32'(ackM));
        checkVal("busy",   32'(busy),   32'(busyM));
        checkVal("expire", 32'(expire), 32'(expM));
    endtask

    function automatic int firstTickAfter(input int c);
        int t;
        t = c - (c % DIV) + DIV - 1;
        if (t <= c) t = t + DIV;
        return t;
    endfunction

    // Advance the model by one cycle using the inputs applied in cycle cyc.
    task automatic modelStep();
        logic [3:0] elig;
        logic [3:0] newAck;
        logic [3:0] newExp;
        int         g;
        int         idx;
        elig   = req & ~cancel & ~ackM;
        g      = -1;
        for (int i = 0; i < NCH; i++) begin
            idx = (ptrM + i) % NCH;
            if (g < 0 && elig[idx]) g = idx;
        end
        newAck = '0;
        newExp = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cancel[k]) begin
                busyM[k] = 1'b0;
                expAt[k] = -1;
            end else if (k == g) begin
                newAck[k] = 1'b1;
                if (delayReg[k] == 16'd0) begin
                    busyM[k]  = 1'b0;
                    newExp[k] = 1'b1;
                    expAt[k]  = -1;
                end else begin
                    busyM[k] = 1'b1;
                    expAt[k] = firstTickAfter(cyc) + (int'(delayReg[k]) - 1) * DIV + 1;
                end
            end else if (busyM[k] && expAt[k] == cyc + 1) begin
                busyM[k]  = 1'b0;
                newExp[k] = 1'b1;
                expAt[k]  = -1;
            end
        end
        if (g >= 0) ptrM = (g + 1) % NCH;
        ackM = newAck;
        expM = newExp;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] cn);
        req    = r;
        cancel = cn;
        delay  = {delayReg[3], delayReg[2], delayReg[1], delayReg[0]};
    endtask

    // One cycle: drive inputs at the negedge, let the posedge happen, then
    // check the next cycle's outputs at its negedge. Requesters keep req high
    // during their ack cycle and drop it afterwards.
    task automatic stepOne();
        for (int k = 0; k < NCH; k++) begin
            if (autoRe[k] && reraiseAt[k] == cyc) want[k] = 1'b1;
        end
        applyStimulus(want, cancelNext);
        for (int k = 0; k < NCH; k++) begin
            if (ackM[k]) begin
                want[k] = 1'b0;
                if (autoRe[k]) reraiseAt[k] = cyc + 3;
            end
        end
        modelStep();
        cancelNext = '0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        checkOutput();
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock.
    task automatic doReset();
        #2 rst_n = 1'b0;
        want       = '0;
        autoRe     = '0;
        cancelNext = '0;
        applyStimulus('0, '0);
        #1;
        checkVal("rst_tick",   32'(tick),   32'd0);
        checkVal("rst_ack",    32'(ack),    32'd0);
        checkVal("rst_busy",   32'(busy),   32'd0);
        checkVal("rst_expire", 32'(expire), 32'd0);
        busyM = '0;
        ackM  = '0;
        expM  = '0;
        ptrM  = 0;
        for (int k = 0; k < NCH; k++) begin
            expAt[k]     = -1;
            reraiseAt[k] = -1;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        int  n1;
        int  n3;
        int  expectNext;
        logic seen;

        tbl[0] = '{cyc: 5,  raise: 4'b1111, ackE: 4'b0000, busyE: 4'b0000, expE: 4'b0000};
        tbl[1] = '{cyc: 6,  raise: 4'b0000, ackE: 4'b0001, busyE: 4'b0001, expE: 4'b0000};
        tbl[2] = '{cyc: 7,  raise: 4'b0000, ackE: 4'b0010, busyE: 4'b0011, expE: 4'b0000};
        tbl[3] = '{cyc: 8,  raise: 4'b0000, ackE: 4'b0100, busyE: 4'b0111, expE: 4'b0000};
        tbl[4] = '{cyc: 9,  raise: 4'b0000, ackE: 4'b1000, busyE: 4'b1111, expE: 4'b0000};
        tbl[5] = '{cyc: 10, raise: 4'b0000, ackE: 4'b0000, busyE: 4'b1111, expE: 4'b0000};
        tbl[6] = '{cyc: 47, raise: 4'b0000, ackE: 4'b0000, busyE: 4'b1111, expE: 4'b0000};
        tbl[7] = '{cyc: 48, raise: 4'b0000, ackE: 4'b0000, busyE: 4'b0000, expE: 4'b1111};
        tbl[8] = '{cyc: 49, raise: 4'b0000, ackE: 4'b0000, busyE: 4'b0000, expE: 4'b0000};

        rst_n = 1'b0;
        for (int k = 0; k < NCH; k++) delayReg[k] = 16'd0;
        doReset();

        // Single load of 3 ticks on ch0 at cycle 10.
        $display("[TB] single load");
        delayReg[0] = 16'd3;
        while (cyc < 10) stepOne();
        want[0] = 1'b1;
        stepOne();
        checkVal("t1_ack",  32'(ack),  32'b0001);
        checkVal("t1_busy", 32'(busy), 32'b0001);
        while (cyc < 46) stepOne();
        checkVal("t1_tick46", 32'(tick), 32'd0);
        stepOne();
        checkVal("t1_tick47", 32'(tick), 32'd1);
        while (cyc < 143) stepOne();
        checkVal("t1_exp143", 32'(expire), 32'b0000);
        stepOne();
        checkVal("t1_exp144",  32'(expire), 32'b0001);
        checkVal("t1_busy144", 32'(busy),   32'b0000);
        stepOne();
        checkVal("t1_busy145", 32'(busy), 32'b0000);

        // All four channels at once, from the vector table.
        $display("[TB] all channels request together");
        doReset();
        for (int k = 0; k < NCH; k++) delayReg[k] = 16'd1;
        for (int c = 0; c < 50; c++) begin
            for (int r = 0; r < 9; r++) begin
                if (tbl[r].cyc == cyc) begin
                    checkVal("t2_ack",    32'(ack),    32'(tbl[r].ackE));
                    checkVal("t2_busy",   32'(busy),   32'(tbl[r].busyE));
                    checkVal("t2_expire", 32'(expire), 32'(tbl[r].expE));
                    want = want | tbl[r].raise;
                end
            end
            stepOne();
        end
        checkVal("t2_ptr", 32'(dut.ptr), 32'd0);

        // Fairness between ch1 and ch3 re-requesting after each ack.
        $display("[TB] fairness");
        delayReg[1] = 16'd100;
        delayReg[3] = 16'd100;
        autoRe      = 4'b1010;
        want        = 4'b1010;
        n1          = 0;
        n3          = 0;
        expectNext  = 1;
        for (int i = 0; i < 20; i++) begin
            stepOne();
            if (ack != 4'b0000) begin
                checkVal("t3_order", 32'(ack), 32'(1 << expectNext));
                expectNext = (expectNext == 1) ? 3 : 1;
            end
            if (ack[1]) n1++;
            if (ack[3]) n3++;
        end
        checkVal("t3_ch1_acks", 32'(n1), 32'd5);
        checkVal("t3_ch3_acks", 32'(n3), 32'd5);
        autoRe = '0;
        repeat (6) stepOne();
        cancelNext = 4'b1010;
        stepOne();

        // Zero delay: ack and expire together, never busy.
        $display("[TB] zero delay");
        delayReg[2] = 16'd0;
        want[2]     = 1'b1;
        stepOne();
        checkVal("t4_ack2",    32'(ack[2]),    32'd1);
        checkVal("t4_expire2", 32'(expire[2]), 32'd1);
        seen = busy[2];
        for (int i = 0; i < 10; i++) begin
            stepOne();
            seen = seen | busy[2];
        end
        checkVal("t4_busy2_never", 32'(seen), 32'd0);

        // Cancel two ticks into a 5-tick delay.
        $display("[TB] cancel");
        doReset();
        delayReg[0] = 16'd5;
        while (cyc < 10) stepOne();
        want[0] = 1'b1;
        while (cyc < 100) stepOne();
        checkVal("t5_busy_before", 32'(busy[0]), 32'd1);
        cancelNext[0] = 1'b1;
        stepOne();
        checkVal("t5_busy_after", 32'(busy[0]), 32'd0);
        seen = 1'b0;
        while (cyc < 300) begin
            stepOne();
            seen = seen | expire[0];
        end
        checkVal("t5_no_expire", 32'(seen), 32'd0);

        // Cancel and request together on ch1.
        delayReg[1]   = 16'd2;
        want[1]       = 1'b1;
        cancelNext[1] = 1'b1;
        stepOne();
        checkVal("t5_ack_blocked", 32'(ack[1]), 32'd0);
        stepOne();
        checkVal("t5_ack_later", 32'(ack[1]), 32'd1);

        // Reset with all channels busy.
        $display("[TB] reset mid-operation");
        for (int k = 0; k < NCH; k++) delayReg[k] = 16'd3;
        want = 4'b1111;
        repeat (8) stepOne();
        checkVal("t6_all_busy", 32'(busy), 32'b1111);
        doReset();
        while (cyc < 46) stepOne();
        checkVal("t6_tick46", 32'(tick), 32'd0);
        stepOne();
        checkVal("t6_tick47", 32'(tick), 32'd1);
        seen = 1'b0;
        while (cyc < 250) begin
            stepOne();
            seen = seen | (|expire);
        end
        checkVal("t6_no_expire", 32'(seen), 32'd0);

        // Random traffic against the model.
        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NCH; k++) begin
                if (!want[k] && !ackM[k] && $urandom_range(0, 9) == 0) begin
                    delayReg[k] = 16'($urandom_range(0, 4));
                    want[k]     = 1'b1;
                end
                if ($urandom_range(0, 39) == 0) cancelNext[k] = 1'b1;
            end
            stepOne();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
